ddr_ch_arbiter: RTL and testbench
=================================

Name: ddr_ch_arbiter

Overview:
Shares one 64-bit-read / 16-bit-write channel of the DDR3 bridge (the ch1-style port: addr[27:1], din[15:0], req/rnw pulse, dout[63:0], ready pulse) among NUM_REQ requesters, for example cart ROM prefetch, DMA, save and debug.
Captures single-cycle request pulses into per-requester slots and grants them round-robin. Issues one transaction at a time downstream and routes the ready pulse back to the owner.
Includes a watchdog so a lost ready never deadlocks the system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 1023, max cycles waiting for ch_ready before forced completion; 0 disables the watchdog

Ports:
DDRAM_CLK  in  1  single clock, same domain as the DDR3 bridge
reset  in  1  synchronous, active-high
rq_addr  in  [NUM_REQ-1:0][27:1]  per-requester halfword address
rq_din  in  [NUM_REQ-1:0][15:0]  per-requester write data
rq_rnw  in  [NUM_REQ-1:0]  1=read, 0=write
rq_req  in  [NUM_REQ-1:0]  1-cycle request pulse
rq_dout  out  64  shared read data, valid on the cycle the owner's rq_ready is high
rq_ready  out  [NUM_REQ-1:0]  1-cycle completion pulse, at most one bit high
ch_addr  out  [27:1]  to bridge channel
ch_din  out  16  to bridge channel
ch_rnw  out  1  to bridge channel
ch_req  out  1  1-cycle pulse to bridge channel
ch_dout  in  64  from bridge channel
ch_ready  in  1  from bridge channel
err_timeout  out  1  sticky: watchdog fired
err_overrun  out  1  sticky: requester pulsed while its slot was pending

Behaviour:
- Clock and reset: one clock, DDRAM_CLK. Reset is synchronous, active-high, named reset.
- Reset values: all outputs 0; slots empty; state IDLE; rr_last = NUM_REQ-1.
- Capture: on any edge where rq_req[k]=1 and slot k is empty, latch addr/din/rnw into slot k and set pend[k].
  - If slot k is already pending, ignore the new request and set err_overrun.
  - Capture happens even while the FSM is in WAIT.
- FSM states: IDLE, WAIT.
- IDLE:
  - If pend != 0, select winner g as the first pending index after rr_last, searching cyclically.
  - Register ch_addr/ch_din/ch_rnw from slot g; pulse ch_req for exactly 1 cycle.
  - Set owner = g and rr_last = g; clear the watchdog; go to WAIT.
  - A slot captured on edge N is eligible for grant at edge N+1, so ch_req is high in cycle N+2 at the earliest.
- WAIT:
  - ch_addr/ch_din/ch_rnw stay stable.
  - On ch_ready: register rq_dout <= ch_dout and rq_ready[owner] <= 1 (high in the next cycle); clear pend[owner]; return to IDLE.
  - The next grant is issued from IDLE one cycle later, so there are no back-to-back ch_req pulses in adjacent cycles.
- Writes use the same path: complete on ch_ready; rq_dout still updates with don't-care data.
- Watchdog (TIMEOUT>0):
  - Counter increments each WAIT cycle.
  - When it reaches TIMEOUT without ch_ready: pulse rq_ready[owner], rq_dout=0, set err_timeout, clear the slot, go to IDLE.
- ch_ready while in IDLE (stray, e.g. after a reset mid-transaction) is ignored.
- Simultaneous events:
  - ch_ready and a new rq_req on the same edge: both handled.
  - The owner may re-request on the edge its rq_ready is high, because its slot is cleared on the same edge.
- Reset mid-WAIT: FSM aborts, all pending requests are dropped, and no rq_ready is issued for them.
- Counter width: clog2(TIMEOUT+1). rr_last width: clog2(NUM_REQ).

Decomposition:
- Package ddr_arb_pkg: ADDR_W=27, RDATA_W=64, WDATA_W=16, state enum arb_state_t {ARB_IDLE, ARB_WAIT}, slot struct arb_slot_t {addr, din, rnw}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: pend vector, rr_last.
  - Outputs: any and grant index.

Test Plan:
1. Single read: rq_req[1] pulse at cycle 0, addr 0x0001000, rnw=1 -> ch_req at cycle 2 with ch_addr 0x0001000. Bridge returns ch_ready with ch_dout 0x1122334455667788 at cycle 5 -> rq_ready=4'b0010 and rq_dout=0x1122334455667788 at cycle 6.
2. Fairness: all four requesters pulse on the same cycle with rr_last=3 -> grant order 0,1,2,3. Requester 0 then re-requests on its ready cycle -> it is served after 3, not before 1.
3. Write: rq_req[2] with rnw=0, addr 0x0000003, din 0xBEEF -> ch_rnw=0, ch_din=0xBEEF, ch_addr=0x0000003. Ready returned only to bit 2.
4. Overrun: requester 0 pulses twice before completion -> err_overrun=1, exactly one ch_req issued, exactly one rq_ready[0].
5. Timeout with TIMEOUT=8: grant issued, ch_ready never asserted -> 8 WAIT cycles later rq_ready[owner]=1, rq_dout=0, err_timeout=1, next pending request granted.
6. Reset in WAIT with two pends -> all outputs 0 the next cycle. A late ch_ready produces no rq_ready; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/ddr_ch_arbiter_pkg.sv
// ddr_arb_pkg: shared widths, FSM state type and request-slot record for
// the DDR3 channel arbiter.
//   ADDR_W  : halfword address width (address bits [27:1])
//   RDATA_W : read data width returned by the bridge channel
//   WDATA_W : write data width accepted by the bridge channel
package ddr_arb_pkg;

    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned RDATA_W = 64;
    localparam int unsigned WDATA_W = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W:1]      addr;
        logic [WDATA_W-1:0]   din;
        logic                 rnw;
    } arb_slot_t;

endpackage

// File: rtl/ddr_ch_arbiter_if.sv
// Bus bundles for the DDR3 channel arbiter.
//   ddr_rq_if : requester side, NUM_REQ lanes of addr/din/rnw/req in,
//               shared rq_dout and one-hot rq_ready back.
//               master = requesters, slave = arbiter.
//   ddr_ch_if : bridge channel side, addr/din/rnw/req out, dout/ready in.
//               master = arbiter, slave = DDR3 bridge.
interface ddr_rq_if #(parameter int unsigned NUM_REQ = 4);
    import ddr_arb_pkg::*;

    logic [NUM_REQ-1:0][ADDR_W:1]    rq_addr;
    logic [NUM_REQ-1:0][WDATA_W-1:0] rq_din;
    logic [NUM_REQ-1:0]              rq_rnw;
    logic [NUM_REQ-1:0]              rq_req;
    logic [RDATA_W-1:0]              rq_dout;
    logic [NUM_REQ-1:0]              rq_ready;

    modport master (output rq_addr, rq_din, rq_rnw, rq_req,
                    input  rq_dout, rq_ready);
    modport slave  (input  rq_addr, rq_din, rq_rnw, rq_req,
                    output rq_dout, rq_ready);
endinterface

interface ddr_ch_if;
    import ddr_arb_pkg::*;

    logic [ADDR_W:1]    ch_addr;
    logic [WDATA_W-1:0] ch_din;
    logic               ch_rnw;
    logic               ch_req;
    logic [RDATA_W-1:0] ch_dout;
    logic               ch_ready;

    modport master (output ch_addr, ch_din, ch_rnw, ch_req,
                    input  ch_dout, ch_ready);
    modport slave  (input  ch_addr, ch_din, ch_rnw, ch_req,
                    output ch_dout, ch_ready);
endinterface

// File: rtl/ddr_ch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   pend    : pending request vector
//   rr_last : index granted most recently
//   any     : at least one request pending
//   grant   : first pending index after rr_last, searching cyclically
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         pend,
    input  logic [$clog2(NUM_REQ)-1:0] rr_last,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] grant
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    // Scan from the farthest candidate (rr_last itself) down to the nearest
    // (rr_last+1) so the last hit is the closest one after rr_last.
    always_comb begin
        int unsigned idx;
        any   = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_last) + NUM_REQ - i) % NUM_REQ;
            if (pend[IW'(idx)]) begin
                any   = 1'b1;
                grant = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/ddr_ch_arbiter.sv
// ddr_ch_arbiter: shares one DDR3 bridge channel (64-bit read, 16-bit write)
// among NUM_REQ requesters. Request pulses are captured into per-requester
// slots, granted round-robin, issued one at a time downstream, and the
// completion pulse is routed back to the owner. A watchdog forces completion
// when ch_ready never arrives.
//   DDRAM_CLK   : clock, bridge domain
//   reset       : synchronous, active-high
//   rq          : requester bundle (slave side)
//   ch          : bridge channel bundle (master side)
//   err_timeout : sticky, watchdog fired
//   err_overrun : sticky, requester pulsed while its slot was pending
module ddr_ch_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic     DDRAM_CLK,
    input  logic     reset,
    ddr_rq_if.slave  rq,
    ddr_ch_if.master ch,
    output logic     err_timeout,
    output logic     err_overrun
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t         state;
    arb_slot_t          slot [NUM_REQ];
    logic [NUM_REQ-1:0] pend;
    logic [IW-1:0]      rr_last;
    logic [IW-1:0]      owner;
    logic [CW-1:0]      wdog;
    logic               any;
    logic [IW-1:0]      grant;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pend    (pend),
        .rr_last (rr_last),
        .any     (any),
        .grant   (grant)
    );

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state       <= ARB_IDLE;
            pend        <= '0;
            rr_last     <= IW'(NUM_REQ - 1);
            owner       <= '0;
            wdog        <= '0;
            ch.ch_addr  <= '0;
            ch.ch_din   <= '0;
            ch.ch_rnw   <= 1'b0;
            ch.ch_req   <= 1'b0;
            rq.rq_dout  <= '0;
            rq.rq_ready <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                slot[k] <= '0;
            end
        end else begin
            ch.ch_req   <= 1'b0;
            rq.rq_ready <= '0;

            // Capture only sets bits that are currently clear, while
            // completion only clears the owner bit, which is set; the two
            // never touch the same pend bit on one edge.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (rq.rq_req[k]) begin
                    if (pend[k]) begin
                        err_overrun <= 1'b1;
                    end else begin
                        slot[k] <= '{addr: rq.rq_addr[k],
                                     din:  rq.rq_din[k],
                                     rnw:  rq.rq_rnw[k]};
                        pend[k] <= 1'b1;
                    end
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        ch.ch_addr <= slot[grant].addr;
                        ch.ch_din  <= slot[grant].din;
                        ch.ch_rnw  <= slot[grant].rnw;
                        ch.ch_req  <= 1'b1;
                        owner      <= grant;
                        rr_last    <= grant;
                        wdog       <= '0;
                        state      <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (ch.ch_ready) begin
                        rq.rq_dout         <= ch.ch_dout;
                        rq.rq_ready[owner] <= 1'b1;
                        pend[owner]        <= 1'b0;
                        state              <= ARB_IDLE;
                    end else if (TIMEOUT != 0 && wdog == WD_LAST) begin
                        // wdog counts WAIT cycles already elapsed, so this
                        // fires at the end of the TIMEOUT-th WAIT cycle.
                        rq.rq_dout         <= '0;
                        rq.rq_ready[owner] <= 1'b1;
                        pend[owner]        <= 1'b0;
                        err_timeout        <= 1'b1;
                        state              <= ARB_IDLE;
                    end else if (TIMEOUT != 0) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_ch_arbiter.sv
// Self-checking bench for ddr_ch_arbiter (NUM_REQ=4, TIMEOUT=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "cycle c" is the interval following rising edge c.
module tb_ddr_ch_arbiter;
    import ddr_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_timeout, err_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ddr_rq_if #(.NUM_REQ(NREQ)) rq ();
    ddr_ch_if ch ();

    ddr_ch_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .DDRAM_CLK   (clk),
        .reset       (reset),
        .rq          (rq),
        .ch          (ch),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    typedef struct {
        logic [3:0]         req;
        int unsigned        ridx;
        logic [ADDR_W:1]    addr;
        logic [WDATA_W-1:0] din;
        logic               rnw;
        logic               rdy;
        logic [63:0]        cdout;
        logic               e_chreq;
        logic [ADDR_W:1]    e_addr;
        logic [WDATA_W-1:0] e_din;
        logic               e_rnw;
        logic [3:0]         e_rdy;
        logic [63:0]        e_dout;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    function automatic vec_t mk(input logic [3:0] req, input int unsigned ridx,
                                input logic [ADDR_W:1] addr, input logic [15:0] din,
                                input logic rnw, input logic rdy, input logic [63:0] cdout,
                                input logic e_chreq, input logic [ADDR_W:1] e_addr,
                                input logic [15:0] e_din, input logic e_rnw,
                                input logic [3:0] e_rdy, input logic [63:0] e_dout);
        vec_t v;
        v.req = req; v.ridx = ridx; v.addr = addr; v.din = din; v.rnw = rnw;
        v.rdy = rdy; v.cdout = cdout; v.e_chreq = e_chreq; v.e_addr = e_addr;
        v.e_din = e_din; v.e_rnw = e_rnw; v.e_rdy = e_rdy; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_rq(input int unsigned k, input logic [ADDR_W:1] a,
                          input logic [15:0] d, input logic rnw);
        rq.rq_addr[k] = a;
        rq.rq_din[k]  = d;
        rq.rq_rnw[k]  = rnw;
    endtask

    task automatic pulse(input logic [3:0] mask);
        rq.rq_req = mask;
        tick();
        rq.rq_req = '0;
    endtask

    task automatic wait_chreq();
        for (int i = 0; i < 20; i++) begin
            if (ch.ch_req) break;
            tick();
        end
        check("grant seen", 64'(ch.ch_req), 64'd1);
    endtask

    // Bridge model: waits for a grant, checks its address, answers after lat
    // cycles, then checks the routed completion.
    task automatic serve(input int unsigned idx, input logic [ADDR_W:1] a,
                         input int lat, input logic [63:0] d);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        wait_chreq();
        check("grant addr", 64'(ch.ch_addr), 64'(a));
        repeat (lat) tick();
        ch.ch_ready = 1'b1;
        ch.ch_dout  = d;
        tick();
        ch.ch_ready = 1'b0;
        check("owner ready", 64'(rq.rq_ready), 64'(onehot));
        check("owner dout", rq.rq_dout, d);
    endtask

    task automatic quiet(input string nm, input int cycles);
        int nreq, nrdy;
        nreq = 0;
        nrdy = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ch.ch_req) nreq++;
            nrdy += $countones(rq.rq_ready);
        end
        check({nm, " extra ch_req"}, 64'(nreq), 64'd0);
        check({nm, " extra rq_ready"}, 64'(nrdy), 64'd0);
    endtask

    initial begin
        int n;
        rq.rq_addr  = '0;
        rq.rq_din   = '0;
        rq.rq_rnw   = '0;
        rq.rq_req   = '0;
        ch.ch_dout  = '0;
        ch.ch_ready = 1'b0;

        // Single read (req 1) then write (req 2); index = cycle number.
        vec[0]  = mk(4'b0010, 1, 27'h0001000, 16'h0000, 1'b1, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[1]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[2]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b1, 27'h0001000, 16'h0000, 1'b1, 4'b0000, 64'h0);
        vec[3]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[4]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[5]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b1, 64'h1122334455667788, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[6]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0010, 64'h1122334455667788);
        vec[7]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[8]  = mk(4'b0100, 2, 27'h0000003, 16'hBEEF, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[9]  = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[10] = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b1, 27'h0000003, 16'hBEEF, 1'b0, 4'b0000, 64'h0);
        vec[11] = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b1, 64'hCAFEF00DDEADBEEF, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);
        vec[12] = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0100, 64'hCAFEF00DDEADBEEF);
        vec[13] = mk(4'b0000, 0, 27'h0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0, 27'h0, 16'h0, 1'b0, 4'b0000, 64'h0);

        // Reset state.
        repeat (3) tick();
        check("reset ch_req", 64'(ch.ch_req), 64'd0);
        check("reset ch_addr", 64'(ch.ch_addr), 64'd0);
        check("reset rq_ready", 64'(rq.rq_ready), 64'd0);
        check("reset rq_dout", rq.rq_dout, 64'd0);
        check("reset err_timeout", 64'(err_timeout), 64'd0);
        check("reset err_overrun", 64'(err_overrun), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d ch_req", i), 64'(ch.ch_req), 64'(vec[i].e_chreq));
            check($sformatf("vec%0d rq_ready", i), 64'(rq.rq_ready), 64'(vec[i].e_rdy));
            if (vec[i].e_chreq) begin
                check($sformatf("vec%0d ch_addr", i), 64'(ch.ch_addr), 64'(vec[i].e_addr));
                check($sformatf("vec%0d ch_din", i), 64'(ch.ch_din), 64'(vec[i].e_din));
                check($sformatf("vec%0d ch_rnw", i), 64'(ch.ch_rnw), 64'(vec[i].e_rnw));
            end
            if (vec[i].e_rdy != 4'b0000)
                check($sformatf("vec%0d rq_dout", i), rq.rq_dout, vec[i].e_dout);
            rq.rq_req = vec[i].req;
            if (vec[i].req != 4'b0000) set_rq(vec[i].ridx, vec[i].addr, vec[i].din, vec[i].rnw);
            ch.ch_ready = vec[i].rdy;
            ch.ch_dout  = vec[i].cdout;
            tick();
        end
        rq.rq_req = '0;

        // Fairness: all four at once from rr_last=3, then 0 re-requests on its
        // ready cycle and must wait behind 1, 2 and 3.
        do_reset();
        for (int unsigned k = 0; k < NREQ; k++) set_rq(k, 27'(32'h100 * (k + 1)), 16'(k), 1'b1);
        pulse(4'b1111);
        serve(0, 27'h0000100, 1, 64'hA0A0A0A0A0A0A0A0);
        set_rq(0, 27'h00ABCDE, 16'h0, 1'b1);
        pulse(4'b0001);
        serve(1, 27'h0000200, 2, 64'hB1B1B1B1B1B1B1B1);
        serve(2, 27'h0000300, 0, 64'hC2C2C2C2C2C2C2C2);
        serve(3, 27'h0000400, 3, 64'hD3D3D3D3D3D3D3D3);
        serve(0, 27'h00ABCDE, 1, 64'hE4E4E4E4E4E4E4E4);

        // Watchdog: rr_last=0 so requester 1 is granted and never answered.
        set_rq(0, 27'h0000555, 16'h0, 1'b1);
        set_rq(1, 27'h0000AAA, 16'h0, 1'b1);
        pulse(4'b0011);
        wait_chreq();
        check("timeout grant addr", 64'(ch.ch_addr), 64'h0000AAA);
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (rq.rq_ready != '0) break;
        end
        check("timeout wait cycles", 64'(n), 64'(TMO));
        check("timeout rq_ready", 64'(rq.rq_ready), 64'b0010);
        check("timeout rq_dout", rq.rq_dout, 64'd0);
        check("timeout err_timeout", 64'(err_timeout), 64'd1);
        serve(0, 27'h0000555, 1, 64'h0F0F0F0F0F0F0F0F);

        // Overrun: requester 0 pulses twice before completion.
        do_reset();
        set_rq(0, 27'h0000777, 16'h1234, 1'b1);
        pulse(4'b0001);
        pulse(4'b0001);
        check("overrun flag", 64'(err_overrun), 64'd1);
        serve(0, 27'h0000777, 1, 64'h7777777777777777);
        quiet("overrun", 10);

        // Reset in WAIT with two pending requests.
        set_rq(0, 27'h0000111, 16'h0, 1'b1);
        set_rq(1, 27'h0000222, 16'h0, 1'b1);
        pulse(4'b0011);
        wait_chreq();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset ch_req", 64'(ch.ch_req), 64'd0);
        check("midreset ch_addr", 64'(ch.ch_addr), 64'd0);
        check("midreset ch_rnw", 64'(ch.ch_rnw), 64'd0);
        check("midreset rq_ready", 64'(rq.rq_ready), 64'd0);
        check("midreset rq_dout", rq.rq_dout, 64'd0);
        check("midreset err_overrun", 64'(err_overrun), 64'd0);
        ch.ch_ready = 1'b1;
        ch.ch_dout  = 64'h5555AAAA5555AAAA;
        tick();
        ch.ch_ready = 1'b0;
        quiet("midreset", 10);
        set_rq(2, 27'h0123456, 16'h0, 1'b1);
        pulse(4'b0100);
        serve(2, 27'h0123456, 2, 64'h0123456789ABCDEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
